// File: rtl/rca_pkg.sv
// Shared definitions for the ripple-carry adder: default width and a
// bit-level full-add reference used by the assertions.
package rca_pkg;

    localparam int RCA_DEFAULT_N = 8;

    // Returns {carry, sum} of a single-bit full add.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        logic s;
        logic co;
        s  = a ^ b ^ c;
        co = (a & b) | (c & (a ^ b));
        return {co, s};
    endfunction

endpackage

// File: rtl/full_adder.sv
// Combinational 1-bit full adder; one cell of the ripple chain.
module full_adder
    import rca_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

    always_comb begin
        assert ({cout, s} == full_add(a, b, cin))
            else $error("full_adder cell disagrees with full_add reference");
    end

endmodule

// File: rtl/ripple_carry_adder_n.sv
// N-bit ripple-carry adder with one output register stage.
// Optional macro RCA_OVERFLOW_EN adds a registered signed-overflow output.
module ripple_carry_adder_n
    import rca_pkg::*;
#(
    parameter int N = RCA_DEFAULT_N
)
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         cin,
    output logic         out_valid,
    output logic [N-1:0] sum,
    output logic         cout
`ifdef RCA_OVERFLOW_EN
    ,
    output logic         overflow
`endif
);

    logic [N:0]   c;
    logic [N-1:0] s_comb;

    assign c[0] = cin;

    // Explicit carry chain: bit i consumes c[i] and produces c[i+1].
    for (genvar i = 0; i < N; i++) begin : g_chain
        full_adder u_fa (
            .a    (A[i]),
            .b    (B[i]),
            .cin  (c[i]),
            .s    (s_comb[i]),
            .cout (c[i+1])
        );
    end

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge value of its inputs, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
        end else begin
            out_valid <= in_valid;
            // Result registers only load on valid input; otherwise they hold.
            if (in_valid) begin
                sum  <= s_comb;
                cout <= c[N];
            end
        end
    end

`ifdef RCA_OVERFLOW_EN
    // Signed overflow: carry into the sign bit differs from carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (in_valid) begin
            overflow <= c[N] ^ c[N-1];
        end
    end
`endif

endmodule

// File: tb/tb_ripple_carry_adder_n.sv
// Directed and random-sweep bench for ripple_carry_adder_n at N = 1, 8, 16.
// Build with +define+RCA_OVERFLOW_EN to also exercise the overflow output.
module tb_ripple_carry_adder_n;

    logic clk;
    logic rst_n;

    // N = 8 instance
    logic       iv8, ci8, ov8, co8;
    logic [7:0] a8, b8, s8;
`ifdef RCA_OVERFLOW_EN
    logic       of8;
`endif

    // N = 1 instance
    logic       iv1, ci1, ov1, co1;
    logic [0:0] a1, b1, s1;
`ifdef RCA_OVERFLOW_EN
    logic       of1;
`endif

    // N = 16 instance
    logic        iv16, ci16, ov16, co16;
    logic [15:0] a16, b16, s16;
`ifdef RCA_OVERFLOW_EN
    logic        of16;
`endif

    int n_vec;
    int n_bad;

    ripple_carry_adder_n #(.N(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .A(a8), .B(b8), .cin(ci8),
        .out_valid(ov8), .sum(s8), .cout(co8)
`ifdef RCA_OVERFLOW_EN
        , .overflow(of8)
`endif
    );

    ripple_carry_adder_n #(.N(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .A(a1), .B(b1), .cin(ci1),
        .out_valid(ov1), .sum(s1), .cout(co1)
`ifdef RCA_OVERFLOW_EN
        , .overflow(of1)
`endif
    );

    ripple_carry_adder_n #(.N(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .A(a16), .B(b16), .cin(ci16),
        .out_valid(ov16), .sum(s16), .cout(co16)
`ifdef RCA_OVERFLOW_EN
        , .overflow(of16)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive the N=8 port on the falling edge, then land just past the next rising edge.
    task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic ci);
        @(negedge clk);
        iv8 = v;
        a8  = a;
        b8  = b;
        ci8 = ci;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_vec++;
        if ({ov8, co8, s8} !== 10'd0) begin
            n_bad++;
            $display("FAIL reset_initial: got ov=%b cout=%b sum=%0d, want 0/0/0", ov8, co8, s8);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Load a result, then pull reset mid-cycle with in_valid still high.
        drive8(1'b1, 8'd200, 8'd100, 1'b1);
        n_vec++;
        if ({ov8, co8, s8} !== {1'b1, 1'b1, 8'd45}) begin
            n_bad++;
            $display("FAIL reset_preload: got ov=%b cout=%b sum=%0d, want 1/1/45", ov8, co8, s8);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({ov8, co8, s8} !== 10'd0) begin
            n_bad++;
            $display("FAIL reset_async: got ov=%b cout=%b sum=%0d, want 0/0/0", ov8, co8, s8);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if ({ov8, co8, s8} !== 10'd0) begin
            n_bad++;
            $display("FAIL reset_held: got ov=%b cout=%b sum=%0d, want 0/0/0", ov8, co8, s8);
        end
        @(negedge clk);
        iv8   = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if ({ov8, co8, s8} !== 10'd0) begin
            n_bad++;
            $display("FAIL reset_no_stale: got ov=%b cout=%b sum=%0d, want 0/0/0", ov8, co8, s8);
        end
    endtask

    task automatic test_directed();
        logic [7:0] va [6];
        logic [7:0] vb [6];
        logic       vc [6];
        logic [8:0] vexp [6];
        va = '{8'd3,  8'd128, 8'd121, 8'd255, 8'd0, 8'd255};
        vb = '{8'd87, 8'd65,  8'd98,  8'd0,   8'd0, 8'd255};
        vc = '{1'b1,  1'b1,   1'b1,   1'b1,   1'b0, 1'b1};
        vexp = '{{1'b0, 8'd91}, {1'b0, 8'd194}, {1'b0, 8'd220},
                 {1'b1, 8'd0},  {1'b0, 8'd0},   {1'b1, 8'd255}};
        for (int i = 0; i < 6; i++) begin
            drive8(1'b1, va[i], vb[i], vc[i]);
            n_vec++;
            if ({ov8, co8, s8} !== {1'b1, vexp[i]}) begin
                n_bad++;
                $display("FAIL directed_%0d: got ov=%b cout=%b sum=%0d, want ov=1 cout=%b sum=%0d",
                         i, ov8, co8, s8, vexp[i][8], vexp[i][7:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        drive8(1'b1, 8'd76, 8'd103, 1'b1);
        n_vec++;
        if ({ov8, co8, s8} !== {1'b1, 1'b0, 8'd180}) begin
            n_bad++;
            $display("FAIL b2b_first: got ov=%b cout=%b sum=%0d, want 1/0/180", ov8, co8, s8);
        end
        drive8(1'b1, 8'd25, 8'd9, 1'b1);
        n_vec++;
        if ({ov8, co8, s8} !== {1'b1, 1'b0, 8'd35}) begin
            n_bad++;
            $display("FAIL b2b_second: got ov=%b cout=%b sum=%0d, want 1/0/35", ov8, co8, s8);
        end
    endtask

    task automatic test_hold();
        drive8(1'b1, 8'd200, 8'd60, 1'b0);
        // Idle cycle with garbage operands: valid drops, result holds.
        drive8(1'b0, 8'd17, 8'd5, 1'b1);
        n_vec++;
        if ({ov8, co8, s8} !== {1'b0, 1'b1, 8'd4}) begin
            n_bad++;
            $display("FAIL hold_idle: got ov=%b cout=%b sum=%0d, want 0/1/4", ov8, co8, s8);
        end
        drive8(1'b1, 8'd17, 8'd5, 1'b1);
        n_vec++;
        if ({ov8, co8, s8} !== {1'b1, 1'b0, 8'd23}) begin
            n_bad++;
            $display("FAIL hold_resume: got ov=%b cout=%b sum=%0d, want 1/0/23", ov8, co8, s8);
        end
    endtask

`ifdef RCA_OVERFLOW_EN
    task automatic test_overflow();
        drive8(1'b1, 8'd127, 8'd1, 1'b0);
        n_vec++;
        if ({of8, co8, s8} !== {1'b1, 1'b0, 8'd128}) begin
            n_bad++;
            $display("FAIL overflow_pos: got of=%b cout=%b sum=%0d, want 1/0/128", of8, co8, s8);
        end
        drive8(1'b1, 8'd3, 8'd87, 1'b1);
        n_vec++;
        if (of8 !== 1'b0) begin
            n_bad++;
            $display("FAIL overflow_none: got of=%b, want 0", of8);
        end
        drive8(1'b1, 8'd128, 8'd128, 1'b0);
        n_vec++;
        if ({of8, co8, s8} !== {1'b1, 1'b1, 8'd0}) begin
            n_bad++;
            $display("FAIL overflow_neg: got of=%b cout=%b sum=%0d, want 1/1/0", of8, co8, s8);
        end
    endtask
`endif

    task automatic test_sweep();
        logic [1:0]  e1;
        logic [8:0]  e8;
        logic [16:0] e16;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            iv1  = 1'b1; a1  = 1'($urandom);  b1  = 1'($urandom);  ci1  = 1'($urandom);
            iv8  = 1'b1; a8  = 8'($urandom);  b8  = 8'($urandom);  ci8  = 1'($urandom);
            iv16 = 1'b1; a16 = 16'($urandom); b16 = 16'($urandom); ci16 = 1'($urandom);
            e1  = 2'(a1)   + 2'(b1)   + 2'(ci1);
            e8  = 9'(a8)   + 9'(b8)   + 9'(ci8);
            e16 = 17'(a16) + 17'(b16) + 17'(ci16);
            @(posedge clk);
            #1;
            n_vec++;
            if ({ov1, co1, s1} !== {1'b1, e1}) begin
                n_bad++;
                $display("FAIL sweep_n1: %0d+%0d+%0d got ov=%b {cout,sum}=%0d want %0d",
                         a1, b1, ci1, ov1, {co1, s1}, e1);
            end
            n_vec++;
            if ({ov8, co8, s8} !== {1'b1, e8}) begin
                n_bad++;
                $display("FAIL sweep_n8: %0d+%0d+%0d got ov=%b {cout,sum}=%0d want %0d",
                         a8, b8, ci8, ov8, {co8, s8}, e8);
            end
            n_vec++;
            if ({ov16, co16, s16} !== {1'b1, e16}) begin
                n_bad++;
                $display("FAIL sweep_n16: %0d+%0d+%0d got ov=%b {cout,sum}=%0d want %0d",
                         a16, b16, ci16, ov16, {co16, s16}, e16);
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        iv8  = 1'b0; a8  = '0; b8  = '0; ci8  = 1'b0;
        iv1  = 1'b0; a1  = '0; b1  = '0; ci1  = 1'b0;
        iv16 = 1'b0; a16 = '0; b16 = '0; ci16 = 1'b0;

        test_reset();
        test_directed();
        test_back_to_back();
        test_hold();
`ifdef RCA_OVERFLOW_EN
        test_overflow();
`endif
        test_sweep();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
